// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access sequencer with sizing, alignment checks and bus timeout
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  MisalignedErr,
  output logic                  BusErr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [1:0] off, o;
  logic [2:0] f3;
  logic req, bad;
  logic [3:0] be;
  logic [DATA_WIDTH-1:0] sh, ext;
  always_comb begin
    req = MemRead | MemWrite;
    o = ALUResult[1:0];
    bad = funct3[1:0] == 2'b11 || (funct3[2] && (MemWrite || funct3[1]))
       || (funct3[1:0] == 2'b01 && o[0]) || (funct3[1:0] == 2'b10 && o != 2'b00);
    be = funct3[1:0] == 2'b00 ? 4'b0001 << o : funct3[1:0] == 2'b01 ? 4'b0011 << o : 4'b1111;
    sh = mem_rdata >> {off, 3'b000};
    ext = f3 == 3'b000 ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]}
        : f3 == 3'b001 ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]}
        : f3 == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]}
        : f3 == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]}
        : sh;
    Stall = state == BUSY || (state == IDLE && req);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      ReadData <= '0;
      MisalignedErr <= 1'b0;
      BusErr <= 1'b0;
      cnt <= '0;
      off <= '0;
      f3 <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (bad) begin
            MisalignedErr <= 1'b1;
            ReadData <= '0;
            state <= DONE;
          end else begin
            mem_req <= 1'b1;
            mem_we <= MemWrite;
            mem_addr <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
            mem_be <= be;
            mem_wdata <= WriteData << {o, 3'b000};
            off <= o;
            f3 <= funct3;
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadData <= ext;
            state <= DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            BusErr <= 1'b1;
            ReadData <= '0;
            state <= DONE;
          end
        end
        default: begin
          MisalignedErr <= 1'b0;
          BusErr <= 1'b0;
          cnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed accesses checked every cycle against a transaction-level model
module tb_load_store_unit;
  localparam int TO = 16;
  logic clk = 0, rst = 1, MemWrite = 0, MemRead = 0, mem_ready = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] ALUResult = 0, WriteData = 0, mem_rdata = 32'hA5A5A5A5;
  logic [31:0] ReadData, mem_addr, mem_wdata;
  logic Stall, MisalignedErr, BusErr, mem_req, mem_we;
  logic [3:0] mem_be;
  int tests = 0, fails = 0, stall_cnt = 0, req_cnt = 0;
  logic chk_en = 0, exp_stall = 0, exp_req = 0, exp_mis = 0, exp_bus = 0, exp_we = 0;
  logic [31:0] exp_rd = 0, exp_addr = 0, exp_wdata = 0, cap_wdata = 0;
  logic [3:0] exp_be = 0, cap_be = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .MisalignedErr(MisalignedErr), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("stall", 32'(Stall), 32'(exp_stall));
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("ReadData", ReadData, exp_rd);
    chk("MisalignedErr", 32'(MisalignedErr), 32'(exp_mis));
    chk("BusErr", 32'(BusErr), 32'(exp_bus));
    if (exp_req) begin
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_be", 32'(mem_be), 32'(exp_be));
      chk("mem_wdata", mem_wdata, exp_wdata);
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      cap_be = mem_be;
      cap_wdata = mem_wdata;
    end
    stall_cnt += int'(Stall);
    req_cnt += int'(mem_req);
  end

  // Access size in bytes is 1<<funct3[1:0]; legal only if the address is a multiple of it.
  function automatic void model(input logic w, input logic [2:0] f, input logic [31:0] a, wd, rdv,
                                output logic ok, output logic [3:0] be, output logic [31:0] wdat, res);
    int sz = 1 << f[1:0];
    int o = int'(a[1:0]);
    logic [63:0] v, mask;
    ok = f[1:0] != 2'b11 && !(f[2] && (w || f[1:0] == 2'b10)) && (o % sz == 0);
    be = 4'(((1 << sz) - 1) << o);
    wdat = wd << (8 * o);
    v = 64'(rdv >> (8 * o));
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v = v & mask;
    if (!f[2] && v[8 * sz - 1]) v = v | ~mask;
    res = v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic w, r, input logic [2:0] f, input logic [31:0] a, wd, rdv,
                        input int waits, input int rst_at);
    logic ok;
    logic [3:0] be;
    logic [31:0] wdat, res;
    int n;
    model(w, f, a, wd, rdv, ok, be, wdat, res);
    stall_cnt = 0;
    req_cnt = 0;
    MemWrite = w; MemRead = r; funct3 = f; ALUResult = a; WriteData = wd;
    exp_stall = 1; exp_req = 0; exp_mis = 0; exp_bus = 0;
    exp_addr = {a[31:2], 2'b00}; exp_be = be; exp_wdata = wdat; exp_we = w;
    n = !ok ? 0 : waits >= 0 ? waits + 1 : TO;
    for (int i = 0; i < n; i++) begin
      step();
      exp_req = 1;
      rst = (i == rst_at);
      mem_ready = (i == waits);
      mem_rdata = mem_ready ? rdv : 32'hA5A5A5A5;
      if (rst) begin
        step();
        rst = 0; MemWrite = 0; MemRead = 0;
        exp_stall = 0; exp_req = 0; exp_rd = 0;
        step();
        return;
      end
    end
    step();
    mem_ready = 0;
    mem_rdata = 32'hA5A5A5A5;
    exp_stall = 0; exp_req = 0; exp_mis = !ok; exp_bus = ok && waits < 0;
    exp_rd = (!ok || waits < 0) ? 32'h0 : (w ? exp_rd : res);
    step();
    MemWrite = 0; MemRead = 0; exp_mis = 0; exp_bus = 0;
    step();
  endtask

  initial begin
    step();
    chk_en = 1;
    step();
    rst = 0;
    step();
    chk("rst_be", 32'(mem_be), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    mem_ready = 1;
    step();
    mem_ready = 0;
    step();
    access(0, 1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, -1);
    chk("lw_rd", ReadData, 32'hDEADBEEF);
    chk("lw_stall", stall_cnt, 2);
    access(0, 1, 3'b000, 32'h103, 0, 32'h80000000, 0, -1);
    chk("lb_rd", ReadData, 32'hFFFFFF80);
    chk("lb_be", 32'(cap_be), 32'h8);
    access(0, 1, 3'b100, 32'h103, 0, 32'h80000000, 1, -1);
    chk("lbu_rd", ReadData, 32'h00000080);
    access(0, 1, 3'b001, 32'h102, 0, 32'h80011234, 0, -1);
    chk("lh_rd", ReadData, 32'hFFFF8001);
    access(0, 1, 3'b101, 32'h102, 0, 32'h80011234, 2, -1);
    chk("lhu_rd", ReadData, 32'h00008001);
    access(1, 0, 3'b001, 32'h202, 32'h1234ABCD, 0, 3, -1);
    chk("sh_stall", stall_cnt, 5);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD0000);
    chk("sh_rd_kept", ReadData, 32'h00008001);
    access(1, 0, 3'b000, 32'h101, 32'h000000C3, 0, 0, -1);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'h0000C300);
    access(1, 1, 3'b010, 32'h300, 32'h11223344, 32'hFFFFFFFF, 1, -1);
    chk("sw_both_wdata", cap_wdata, 32'h11223344);
    access(0, 1, 3'b010, 32'h101, 0, 0, 0, -1);
    chk("lw_mis_stall", stall_cnt, 1);
    chk("lw_mis_req", req_cnt, 0);
    access(1, 0, 3'b001, 32'h203, 32'h5555, 0, 0, -1);
    access(0, 1, 3'b011, 32'h100, 0, 0, 0, -1);
    chk("f3_011_req", req_cnt, 0);
    access(1, 0, 3'b100, 32'h100, 32'h77, 0, 0, -1);
    access(0, 1, 3'b010, 32'h44, 0, 32'h0BADF00D, 0, -1);
    access(0, 1, 3'b010, 32'h40, 0, 0, -1, -1);
    chk("to_req", req_cnt, 16);
    chk("to_stall", stall_cnt, 17);
    chk("to_rd", ReadData, 32'h0);
    access(1, 0, 3'b010, 32'h80, 32'hCAFEBABE, 0, 5, 1);
    chk("rst_mid_req", req_cnt, 2);
    access(0, 1, 3'b010, 32'h40, 0, 32'h12345678, 0, -1);
    chk("after_rst_rd", ReadData, 32'h12345678);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
